// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: basic address/data widths, the fetch->decode
// pipe register, the bubble instruction, and the BTB entry / BHT counter types.
// No ports; packages only.

package BasicTypes;
   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   typedef logic [ADDR_WIDTH-1:0] AddrPath;
   typedef logic [DATA_WIDTH-1:0] DataPath;
endpackage

package PipelineTypes;
   import BasicTypes::*;

   typedef struct packed {
      AddrPath pc;
      DataPath inst;
      logic    isBranchTakenPredicted;
      logic    isNextPcPredicted;
      AddrPath predictedNextPC;
   } FetchStagePipeReg;

   // addi x0, x0, 0 (canonical NOP) fills the pipe on redirect and reset
   localparam DataPath BUBBLE_INST = 32'h0000_0013;

   localparam FetchStagePipeReg FETCH_BUBBLE = '{
      pc                     : '0,
      inst                   : BUBBLE_INST,
      isBranchTakenPredicted : 1'b0,
      isNextPcPredicted      : 1'b0,
      predictedNextPC        : '0
   };

   // Tag is stored zero-extended to the full address width so the entry
   // type does not depend on the BTB depth.
   typedef struct packed {
      logic    valid;
      AddrPath tag;
      AddrPath target;
   } BtbEntry;

   typedef logic [1:0] BhtCounter;

   localparam BhtCounter BHT_RESET = 2'b01;  // weakly not-taken
   localparam BhtCounter BHT_ALLOC = 2'b10;  // weakly taken

   function automatic BhtCounter bht_next(input BhtCounter c, input logic taken);
      BhtCounter n;
      n = c;
      if (taken) begin
         if (c != 2'b11) n = c + 2'b01;
      end else begin
         if (c != 2'b00) n = c - 2'b01;
      end
      return n;
   endfunction
endpackage

// File: rtl/fetch_stage_branch_predictor.sv
// Direct-mapped BTB plus 2-bit BHT with resolved-branch update logic.
// Ports: clk_i/rst_i; lookup_pc_i -> hit_o/taken_o/next_pc_o (combinational);
//        upd_en_i/upd_pc_i/upd_taken_i/upd_target_i (applied at the rising edge).

module branch_predictor
   import BasicTypes::*;
   import PipelineTypes::*;
#(
   parameter int BTB_ENTRIES = 16
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  AddrPath lookup_pc_i,
   output logic    hit_o,
   output logic    taken_o,
   output AddrPath next_pc_o,
   input  logic    upd_en_i,
   input  AddrPath upd_pc_i,
   input  logic    upd_taken_i,
   input  AddrPath upd_target_i
);
   localparam int IDX_W     = $clog2(BTB_ENTRIES);
   localparam int TAG_SHIFT = IDX_W + 2;

   typedef logic [IDX_W-1:0] idx_t;

   BtbEntry   btb_q [BTB_ENTRIES];
   BhtCounter bht_q [BTB_ENTRIES];

   idx_t    lk_idx;
   AddrPath lk_tag;
   idx_t    upd_idx;
   AddrPath upd_tag;
   logic    upd_hit;

   BtbEntry   upd_entry_d;
   BhtCounter upd_cnt_d;
   logic      upd_wr_entry;
   logic      upd_wr_cnt;

   assign lk_idx  = lookup_pc_i[IDX_W+1:2];
   assign lk_tag  = lookup_pc_i >> TAG_SHIFT;
   assign upd_idx = upd_pc_i[IDX_W+1:2];
   assign upd_tag = upd_pc_i >> TAG_SHIFT;

   // Lookup reads the registered arrays, so a same-cycle update to the same
   // index is only visible from the next cycle on.
   assign hit_o     = btb_q[lk_idx].valid && (btb_q[lk_idx].tag == lk_tag);
   assign taken_o   = hit_o && bht_q[lk_idx][1];
   assign next_pc_o = taken_o ? btb_q[lk_idx].target : (lookup_pc_i + 32'd4);

   assign upd_hit = btb_q[upd_idx].valid && (btb_q[upd_idx].tag == upd_tag);

   always_comb begin
      upd_entry_d  = btb_q[upd_idx];
      upd_cnt_d    = bht_q[upd_idx];
      upd_wr_entry = 1'b0;
      upd_wr_cnt   = 1'b0;
      if (upd_en_i) begin
         if (upd_hit) begin
            upd_wr_cnt = 1'b1;
            upd_cnt_d  = bht_next(bht_q[upd_idx], upd_taken_i);
            if (upd_taken_i) begin
               upd_wr_entry       = 1'b1;
               upd_entry_d.target = upd_target_i;
            end
         end else if (upd_taken_i) begin
            // Not-taken misses are dropped: nothing worth predicting yet.
            upd_wr_entry = 1'b1;
            upd_wr_cnt   = 1'b1;
            upd_entry_d  = '{valid: 1'b1, tag: upd_tag, target: upd_target_i};
            upd_cnt_d    = BHT_ALLOC;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0};
            bht_q[i] <= BHT_RESET;
         end
      end else begin
         if (upd_wr_entry) btb_q[upd_idx] <= upd_entry_d;
         if (upd_wr_cnt)   bht_q[upd_idx] <= upd_cnt_d;
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, branch prediction lookup, and fetch->decode pipe register.
// Ports: clk/rst; imemAddr/imemData to instruction memory; isDataHazard stall,
//        isBranchPredictMiss/correctPC redirect; bpUpdate* training; nextStage to decode.

module fetch_stage
   import BasicTypes::*;
   import PipelineTypes::*;
#(
   parameter AddrPath RESET_PC    = 32'h0000_0000,
   parameter int      BTB_ENTRIES = 16
) (
   input  logic             clk,
   input  logic             rst,
   output AddrPath          imemAddr,
   input  DataPath          imemData,
   input  logic             isDataHazard,
   input  logic             isBranchPredictMiss,
   input  AddrPath          correctPC,
   input  logic             bpUpdateEnable,
   input  AddrPath          bpUpdatePC,
   input  logic             bpUpdateTaken,
   input  AddrPath          bpUpdateTarget,
   output FetchStagePipeReg nextStage
);
   AddrPath          pc_q;
   AddrPath          pc_d;
   FetchStagePipeReg pipe_q;
   FetchStagePipeReg pipe_d;

   logic    pred_hit;
   logic    pred_taken;
   AddrPath pred_next_pc;

   branch_predictor #(
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_bp (
      .clk_i        (clk),
      .rst_i        (rst),
      .lookup_pc_i  (pc_q),
      .hit_o        (pred_hit),
      .taken_o      (pred_taken),
      .next_pc_o    (pred_next_pc),
      .upd_en_i     (bpUpdateEnable),
      .upd_pc_i     (bpUpdatePC),
      .upd_taken_i  (bpUpdateTaken),
      .upd_target_i (bpUpdateTarget)
   );

   assign imemAddr  = pc_q;
   assign nextStage = pipe_q;

   // Redirect beats stall: a mispredict squashes whatever decode is holding.
   always_comb begin
      pc_d   = pc_q;
      pipe_d = pipe_q;
      if (isBranchPredictMiss) begin
         pc_d   = correctPC;
         pipe_d = FETCH_BUBBLE;
      end else if (!isDataHazard) begin
         pc_d   = pred_next_pc;
         pipe_d = '{
            pc                     : pc_q,
            inst                   : imemData,
            isBranchTakenPredicted : pred_taken,
            isNextPcPredicted      : pred_hit,
            predictedNextPC        : pred_next_pc
         };
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         pipe_q <= FETCH_BUBBLE;
      end else begin
         pc_q   <= pc_d;
         pipe_q <= pipe_d;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized traffic,
// all checked against a cycle-level reference model of PC, pipe register and BTB/BHT.
// Ports: none (top-level bench).

module tb_fetch_stage;
   import BasicTypes::*;
   import PipelineTypes::*;

   localparam int          N   = 16;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic             clk = 1'b0;
   logic             rst;
   AddrPath          imemAddr;
   DataPath          imemData;
   logic             isDataHazard;
   logic             isBranchPredictMiss;
   AddrPath          correctPC;
   logic             bpUpdateEnable;
   AddrPath          bpUpdatePC;
   logic             bpUpdateTaken;
   AddrPath          bpUpdateTarget;
   FetchStagePipeReg nextStage;

   fetch_stage #(
      .RESET_PC    (RPC),
      .BTB_ENTRIES (N)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .imemAddr            (imemAddr),
      .imemData            (imemData),
      .isDataHazard        (isDataHazard),
      .isBranchPredictMiss (isBranchPredictMiss),
      .correctPC           (correctPC),
      .bpUpdateEnable      (bpUpdateEnable),
      .bpUpdatePC          (bpUpdatePC),
      .bpUpdateTaken       (bpUpdateTaken),
      .bpUpdateTarget      (bpUpdateTarget),
      .nextStage           (nextStage)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [31:0] m_pc;
   logic [31:0] e_pc, e_inst, e_npc;
   logic        e_tk, e_np;
   bit          mv   [N];
   logic [31:0] mtag [N];
   logic [31:0] mtgt [N];
   int          mctr [N];

   task automatic model_lookup(input logic [31:0] pc, output bit hit, output bit tk,
                               output logic [31:0] npc);
      int i;
      i   = int'((pc / 4) % N);
      hit = mv[i] && (mtag[i] == pc / (4 * N));
      tk  = hit && (mctr[i] >= 2);
      npc = tk ? mtgt[i] : pc + 32'd4;
   endtask

   task automatic step(input bit r, input bit miss, input logic [31:0] cpc, input bit haz,
                       input bit ue, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utg);
      bit          hit, tk;
      logic [31:0] npc;
      int          ui;
      rst                 = r;
      isBranchPredictMiss = miss;
      correctPC           = cpc;
      isDataHazard        = haz;
      bpUpdateEnable      = ue;
      bpUpdatePC          = upc;
      bpUpdateTaken       = ut;
      bpUpdateTarget      = utg;
      imemData            = $urandom;

      if (r) begin
         m_pc = RPC;
         e_pc = 0; e_inst = 32'h13; e_tk = 0; e_np = 0; e_npc = 0;
         for (int i = 0; i < N; i++) begin
            mv[i] = 0; mctr[i] = 1;
         end
      end else begin
         model_lookup(m_pc, hit, tk, npc);
         if (miss) begin
            m_pc = cpc;
            e_pc = 0; e_inst = 32'h13; e_tk = 0; e_np = 0; e_npc = 0;
         end else if (!haz) begin
            e_pc = m_pc; e_inst = imemData; e_tk = tk; e_np = hit; e_npc = npc;
            m_pc = npc;
         end
         if (ue) begin
            ui = int'((upc / 4) % N);
            if (mv[ui] && mtag[ui] == upc / (4 * N)) begin
               mctr[ui] = ut ? ((mctr[ui] < 3) ? mctr[ui] + 1 : 3)
                             : ((mctr[ui] > 0) ? mctr[ui] - 1 : 0);
               if (ut) mtgt[ui] = utg;
            end else if (ut) begin
               mv[ui] = 1; mtag[ui] = upc / (4 * N); mtgt[ui] = utg; mctr[ui] = 2;
            end
         end
      end

      @(posedge clk);
      #1;
      check_eq("imemAddr",  imemAddr, m_pc);
      check_eq("ns.pc",     nextStage.pc, e_pc);
      check_eq("ns.inst",   nextStage.inst, e_inst);
      check_eq("ns.taken",  {31'b0, nextStage.isBranchTakenPredicted}, {31'b0, e_tk});
      check_eq("ns.hit",    {31'b0, nextStage.isNextPcPredicted}, {31'b0, e_np});
      check_eq("ns.npc",    nextStage.predictedNextPC, e_npc);
   endtask

   task automatic fetch();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic redirect(input logic [31:0] t);
      step(0, 1, t, 0, 0, 0, 0, 0);
   endtask

   function automatic logic [31:0] rand_pc();
      if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
      return 32'($urandom_range(0, 47)) * 4;
   endfunction

   initial begin
      rst = 1; isDataHazard = 0; isBranchPredictMiss = 0; correctPC = 0;
      bpUpdateEnable = 0; bpUpdatePC = 0; bpUpdateTaken = 0; bpUpdateTarget = 0;
      imemData = 0;
      m_pc = RPC;

      // Reset and straight-line fetch from 0
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check_eq("rst_pc", imemAddr, RPC);
      check_eq("rst_inst", nextStage.inst, 32'h13);
      for (int i = 0; i < 4; i++) fetch();
      check_eq("line_addr", imemAddr, 32'h10);
      check_eq("line_nspc", nextStage.pc, 32'h0C);

      // Three-cycle stall at 0x10
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1, 0, 0, 0, 0);
         check_eq("stall_addr", imemAddr, 32'h10);
      end
      fetch();
      check_eq("resume_addr", imemAddr, 32'h14);

      // Allocate 0x20 -> 0x80 during a stall, then refetch 0x20
      step(0, 0, 0, 1, 1, 32'h20, 1, 32'h80);
      redirect(32'h20);
      fetch();
      check_eq("alloc_hit", {31'b0, nextStage.isNextPcPredicted}, 32'd1);
      check_eq("alloc_tk", {31'b0, nextStage.isBranchTakenPredicted}, 32'd1);
      check_eq("alloc_next", imemAddr, 32'h80);

      // Two not-taken updates: 10 -> 01 -> 00
      step(0, 0, 0, 1, 1, 32'h20, 0, 0);
      step(0, 0, 0, 1, 1, 32'h20, 0, 0);
      redirect(32'h20);
      fetch();
      check_eq("weak_hit", {31'b0, nextStage.isNextPcPredicted}, 32'd1);
      check_eq("weak_tk", {31'b0, nextStage.isBranchTakenPredicted}, 32'd0);
      check_eq("weak_next", imemAddr, 32'h24);

      // Redirect wins over stall
      step(0, 1, 32'h100, 1, 0, 0, 0, 0);
      check_eq("mh_inst", nextStage.inst, 32'h13);
      check_eq("mh_addr", imemAddr, 32'h100);

      // Reset during a redirect clears the BTB
      step(1, 1, 32'h200, 0, 1, 32'h40, 1, 32'h44);
      check_eq("rr_addr", imemAddr, RPC);
      redirect(32'h20);
      fetch();
      check_eq("rr_miss", {31'b0, nextStage.isNextPcPredicted}, 32'd0);

      // Wrap-around of PC+4
      redirect(32'hFFFF_FFFC);
      fetch();
      check_eq("wrap", imemAddr, 32'h0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         bit          r, m, h, ue, ut;
         logic [31:0] upc, utg, cpc;
         r   = ($urandom_range(0, 199) == 0);
         m   = ($urandom_range(0, 9) == 0);
         h   = ($urandom_range(0, 4) == 0);
         ue  = ($urandom_range(0, 2) == 0);
         ut  = $urandom_range(0, 1) == 1;
         upc = rand_pc();
         utg = rand_pc();
         cpc = rand_pc();
         step(r, m, cpc, h, ue, upc, ut, utg);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter BTB_ENTRIES, default 16: BTB/BHT depth; power of two, minimum 4.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 imemAddr  out  32  instruction memory address; combinationally equal to the current PC.
REQ-006 imemData  in  32  instruction word; valid in the same cycle as imemAddr.
REQ-007 isDataHazard  in  1  decode stall request.
REQ-008 isBranchPredictMiss  in  1  redirect request from execute.
REQ-009 correctPC  in  32  redirect target; valid with isBranchPredictMiss.
REQ-010 bpUpdateEnable  in  1  resolved control-flow instruction from execute.
REQ-011 bpUpdatePC  in  32  PC of the resolved instruction.
REQ-012 bpUpdateTaken  in  1  resolved direction.
REQ-013 bpUpdateTarget  in  32  resolved taken target.
REQ-014 nextStage  out  FetchStagePipeReg  registered fields {pc, inst, isBranchTakenPredicted, isNextPcPredicted, predictedNextPC} consumed by decode.

Function
REQ-015 Per-cycle priority SHALL be: rst > isBranchPredictMiss > isDataHazard > normal fetch.
REQ-016 On redirect, PC SHALL load correctPC and nextStage SHALL load the bubble (REQ-022).
REQ-017 On stall, PC and nextStage SHALL hold their values.
REQ-018 On normal fetch, nextStage SHALL load {PC, imemData, prediction}, and PC SHALL load predictedNextPC.
REQ-019 Lookup index SHALL be PC[log2(BTB_ENTRIES)+1:2]; tag SHALL be the remaining upper PC bits; hit = valid && tag match.
REQ-020 isNextPcPredicted = hit; isBranchTakenPredicted = hit && counter[1]; predictedNextPC = taken-predicted ? BTB target : PC+4, with 32-bit wrap-around (32'hFFFF_FFFC+4 = 0).
REQ-021 Fetch SHALL have one-cycle latency: an instruction presented at PC in cycle n appears on nextStage after edge n.
REQ-022 The bubble SHALL be pc=0, inst=32'h0000_0013, predicted flags=0, predictedNextPC=0.
REQ-023 When bpUpdateEnable=1 and the update hits, the 2-bit counter SHALL saturate-increment if taken and saturate-decrement otherwise; if taken, the target SHALL be rewritten.
REQ-024 When bpUpdateEnable=1 and the update misses: if taken, the entry SHALL be allocated (valid=1, tag, target, counter=2'b10); if not taken, no change.
REQ-025 Update and lookup in the same cycle on the same index: the lookup SHALL see pre-update contents.
REQ-026 Updates SHALL be applied during stall and redirect cycles.

Reset
REQ-027 rst SHALL set PC=RESET_PC, nextStage=bubble, all BTB valid bits=0, all counters=2'b01.
REQ-028 rst asserted mid-stall or mid-redirect SHALL override both; the first fetch after reset deassertion SHALL be at RESET_PC.

Structure
REQ-029 FetchStagePipeReg, the bubble instruction constant, and the BTB entry typedef SHALL live in PipelineTypes; address/data widths SHALL come from BasicTypes.
REQ-030 The BTB, BHT and update logic SHALL form one sub-module, branch_predictor; the PC register and pipe register SHALL stay in fetch_stage.

Verification
REQ-031 Reset, then run straight-line code from 0: imemAddr = 0,4,8,...; nextStage.pc trails by one cycle; all predicted flags = 0.
REQ-032 isDataHazard=1 for 3 cycles at PC=0x10: imemAddr stays 0x10 and nextStage stays constant; fetch resumes at 0x14.
REQ-033 Update PC=0x20, taken, target=0x80, then refetch 0x20: isNextPcPredicted=1, isBranchTakenPredicted=1, next imemAddr=0x80.
REQ-034 Same entry, 2 not-taken updates: counter 10->01->00; lookup at 0x20 gives hit=1, taken=0, predictedNextPC=0x24.
REQ-035 isBranchPredictMiss and isDataHazard both asserted with correctPC=0x100: nextStage = bubble; next imemAddr = 0x100.
REQ-036 Assert rst during a redirect cycle: PC=RESET_PC; all BTB entries miss afterwards.
